// File: rtl/exec_unit_if.sv
// Operand/opcode request and write-back response bundle between decode,
// the register file and the execute stage.
interface exec_unit_if #(
  parameter int W = 8
);
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         WrEn;
  logic [W-1:0] Result;
  logic         Zero;
  logic         Carry;
  logic         Busy;
  logic         Done;
  logic         RegWrite;

  modport master (
    output Start, Op, A, B, WrEn,
    input  Result, Zero, Carry, Busy, Done, RegWrite
  );

  modport slave (
    input  Start, Op, A, B, WrEn,
    output Result, Zero, Carry, Busy, Done, RegWrite
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shift and shift-add
// multiply, producing the write-back value and strobe for the register file.
module exec_unit #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  exec_unit_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [2:0]     op_q;
  logic           wr_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sh;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [W-1:0]   result_q;
  logic           zero_q;
  logic           carry_q;

  logic [W:0]     alu_ext;
  logic [W-1:0]   sh_next;
  logic           sh_out;
  logic [2*W-1:0] acc_next;
  logic [SW-1:0]  sh_amt;

  // Single-cycle ops; bit W carries the carry-out / borrow.
  always_comb begin
    alu_ext = '0;
    case (bus.Op)
      OP_ADD:  alu_ext = {1'b0, bus.A} + {1'b0, bus.B};
      OP_SUB:  alu_ext = {1'b0, bus.A} - {1'b0, bus.B};
      OP_AND:  alu_ext = {1'b0, bus.A & bus.B};
      OP_XOR:  alu_ext = {1'b0, bus.A ^ bus.B};
      OP_PASS: alu_ext = {1'b0, bus.B};
      default: alu_ext = '0;
    endcase
  end

  always_comb begin
    sh_next = sh;
    sh_out  = 1'b0;
    if (op_q == OP_SHL) begin
      sh_next = {sh[W-2:0], 1'b0};
      sh_out  = sh[W-1];
    end else begin
      sh_next = {1'b0, sh[W-1:1]};
      sh_out  = sh[0];
    end
  end

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign sh_amt = bus.B[SW-1:0];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      wr_q     <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            op_q <= bus.Op;
            wr_q <= bus.WrEn;
            case (bus.Op)
              OP_SHL, OP_SHR: begin
                if (sh_amt == '0) begin
                  result_q <= bus.A;
                  zero_q   <= (bus.A == '0);
                  carry_q  <= 1'b0;
                  state    <= S_DONE;
                end else begin
                  sh    <= bus.A;
                  cnt   <= CW'(sh_amt);
                  state <= S_RUN;
                end
              end
              OP_MUL: begin
                acc    <= '0;
                mcand  <= {{W{1'b0}}, bus.A};
                mplier <= bus.B;
                cnt    <= CW'(W);
                state  <= S_RUN;
              end
              default: begin
                result_q <= alu_ext[W-1:0];
                zero_q   <= (alu_ext[W-1:0] == '0);
                carry_q  <= alu_ext[W];
                state    <= S_DONE;
              end
            endcase
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (op_q == OP_MUL) begin
            acc    <= acc_next;
            mcand  <= {mcand[2*W-2:0], 1'b0};
            mplier <= {1'b0, mplier[W-1:1]};
            // Last step commits from acc_next so the final add is not lost.
            if (cnt == CW'(1)) begin
              result_q <= acc_next[W-1:0];
              zero_q   <= (acc_next[W-1:0] == '0);
              carry_q  <= (acc_next[2*W-1:W] != '0);
              state    <= S_DONE;
            end
          end else begin
            sh <= sh_next;
            if (cnt == CW'(1)) begin
              result_q <= sh_next;
              zero_q   <= (sh_next == '0);
              carry_q  <= sh_out;
              state    <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Busy     = (state == S_RUN) || (state == S_DONE);
  assign bus.Done     = (state == S_DONE);
  assign bus.RegWrite = (state == S_DONE) && wr_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with hand-computed expectations.
module tb_exec_unit;

  logic CLK;
  logic Reset;
  int   errors;
  int   checks;

  exec_unit_if #(.W(8)) bus ();

  exec_unit #(.W(8), .SW(3)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op and stop at the negedge where Done is seen (bounded).
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic wr, output int lat, output int busy_n, output logic rw);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b; bus.WrEn = wr;
    @(negedge CLK);
    bus.Start = 1'b0;
    lat = 0; busy_n = 0;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (bus.Busy === 1'b1) busy_n++;
      @(negedge CLK);
      lat++;
    end
    if (bus.Busy === 1'b1) busy_n++;
    rw = bus.RegWrite;
  endtask

  task automatic after_done(input string tag);
    @(negedge CLK);
    chk({tag, "_done_low"}, {31'd0, bus.Done}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    int   lat;
    int   busy_n;
    logic rw;
    int   done_cnt;
    int   done_at;
    logic [7:0] res_at;

    errors = 0; checks = 0;
    bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0; bus.WrEn = 1'b0;
    Reset = 1'b1;
    #1;
    chk("rst_result", {24'd0, bus.Result}, 32'h0);
    chk("rst_flags", {27'd0, bus.Zero, bus.Carry, bus.Busy, bus.Done, bus.RegWrite}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    // ADD with carry out
    run_op(3'b000, 8'hF0, 8'h20, 1'b1, lat, busy_n, rw);
    chk("add_lat", lat, 0);
    chk("add_busy", busy_n, 1);
    chk("add_regwr", {31'd0, rw}, 32'd1);
    chk("add_res", {24'd0, bus.Result}, 32'h10);
    chk("add_zc", {30'd0, bus.Zero, bus.Carry}, 32'b01);
    after_done("add");
    chk("add_regwr_off", {31'd0, bus.RegWrite}, 32'd0);
    @(negedge CLK);
    chk("hold_res", {24'd0, bus.Result}, 32'h10);

    // SUB equal and borrow
    run_op(3'b001, 8'h05, 8'h05, 1'b1, lat, busy_n, rw);
    chk("sub0_res", {24'd0, bus.Result}, 32'h00);
    chk("sub0_zc", {30'd0, bus.Zero, bus.Carry}, 32'b10);
    run_op(3'b001, 8'h03, 8'h05, 1'b1, lat, busy_n, rw);
    chk("sub1_res", {24'd0, bus.Result}, 32'hFE);
    chk("sub1_zc", {30'd0, bus.Zero, bus.Carry}, 32'b01);

    // Logic ops and PASS
    run_op(3'b010, 8'hCC, 8'hAA, 1'b1, lat, busy_n, rw);
    chk("and_res", {24'd0, bus.Result}, 32'h88);
    run_op(3'b011, 8'hFF, 8'hFF, 1'b1, lat, busy_n, rw);
    chk("xor_res", {24'd0, bus.Result}, 32'h00);
    chk("xor_zc", {30'd0, bus.Zero, bus.Carry}, 32'b10);
    run_op(3'b111, 8'h11, 8'h3C, 1'b0, lat, busy_n, rw);
    chk("pass_res", {24'd0, bus.Result}, 32'h3C);
    chk("pass_regwr", {31'd0, rw}, 32'd0);

    // SHL n=3
    run_op(3'b100, 8'h81, 8'h03, 1'b0, lat, busy_n, rw);
    chk("shl3_lat", lat, 3);
    chk("shl3_busy", busy_n, 4);
    chk("shl3_res", {24'd0, bus.Result}, 32'h08);
    chk("shl3_c", {31'd0, bus.Carry}, 32'd0);
    chk("shl3_regwr", {31'd0, rw}, 32'd0);
    after_done("shl3");

    // SHR n=0 passes A
    run_op(3'b101, 8'h5A, 8'h08, 1'b1, lat, busy_n, rw);
    chk("shr0_lat", lat, 0);
    chk("shr0_res", {24'd0, bus.Result}, 32'h5A);
    chk("shr0_c", {31'd0, bus.Carry}, 32'd0);

    // SHR n=2, last bit out is 1
    run_op(3'b101, 8'h5A, 8'h02, 1'b1, lat, busy_n, rw);
    chk("shr2_lat", lat, 2);
    chk("shr2_res", {24'd0, bus.Result}, 32'h16);
    chk("shr2_c", {31'd0, bus.Carry}, 32'd1);

    // SHL max n=7
    run_op(3'b100, 8'h81, 8'hFF, 1'b1, lat, busy_n, rw);
    chk("shl7_lat", lat, 7);
    chk("shl7_res", {24'd0, bus.Result}, 32'h80);
    chk("shl7_c", {31'd0, bus.Carry}, 32'd0);

    // MUL
    run_op(3'b110, 8'h0D, 8'h0B, 1'b1, lat, busy_n, rw);
    chk("mul1_lat", lat, 8);
    chk("mul1_busy", busy_n, 9);
    chk("mul1_res", {24'd0, bus.Result}, 32'h8F);
    chk("mul1_zc", {30'd0, bus.Zero, bus.Carry}, 32'b00);
    run_op(3'b110, 8'h20, 8'h10, 1'b1, lat, busy_n, rw);
    chk("mul2_res", {24'd0, bus.Result}, 32'h00);
    chk("mul2_zc", {30'd0, bus.Zero, bus.Carry}, 32'b11);

    // Start during MUL RUN is ignored
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'b110; bus.A = 8'h0D; bus.B = 8'h0B; bus.WrEn = 1'b1;
    done_cnt = 0; done_at = -1; res_at = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        bus.Op = 3'b000; bus.A = 8'h01; bus.B = 8'h01;
      end else if (i == 3) begin
        bus.Start = 1'b0;
      end
      if (bus.Done === 1'b1) begin
        done_cnt++;
        done_at = i;
        res_at  = bus.Result;
      end
    end
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_done_at", done_at, 8);
    chk("ign_res", {24'd0, res_at}, 32'h8F);

    // Start held high through DONE is accepted on the following IDLE edge
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'b000; bus.A = 8'hFF; bus.B = 8'h02; bus.WrEn = 1'b1;
    @(negedge CLK);
    chk("hold_d0", {31'd0, bus.Done}, 32'd1);
    chk("hold_res0", {23'd0, bus.Carry, bus.Result}, 32'h101);
    @(negedge CLK);
    chk("hold_d1", {31'd0, bus.Done}, 32'd0);
    @(negedge CLK);
    chk("hold_d2", {31'd0, bus.Done}, 32'd1);
    bus.Start = 1'b0;
    @(negedge CLK);
    chk("hold_d3", {31'd0, bus.Done}, 32'd0);

    // Reset in the 4th RUN cycle of a MUL
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'b110; bus.A = 8'h0D; bus.B = 8'h0B; bus.WrEn = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0;
    chk("mrst_busy", {31'd0, bus.Busy}, 32'd1);
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("mrst_res", {24'd0, bus.Result}, 32'h0);
    chk("mrst_flags", {27'd0, bus.Zero, bus.Carry, bus.Busy, bus.Done, bus.RegWrite}, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.Done === 1'b1 || bus.RegWrite === 1'b1) done_cnt++;
    end
    chk("mrst_no_done", done_cnt, 0);
    run_op(3'b000, 8'h01, 8'h01, 1'b1, lat, busy_n, rw);
    chk("post_rst_lat", lat, 0);
    chk("post_rst_res", {24'd0, bus.Result}, 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
